// File: rtl/full_subtractor_pkg.sv
// Shared constants, result bundle and overflow helper for the full_subtractor block.
package full_subtractor_pkg;

  localparam int FS_DEFAULT_WIDTH = 1;
  localparam int FS_MAX_WIDTH     = 64;

  // Registered result; diff is sized for the widest legal build, upper bits stay zero.
  typedef struct packed {
    logic [FS_MAX_WIDTH-1:0] diff;
    logic                    borrow;
    logic                    ovf;
  } fs_result_t;

  // Signed overflow of a - b: operand signs differ and the result sign flipped away from a.
  function automatic logic fs_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// Gate-level 1-bit full subtractor: d = a - b - bin, with borrow-out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor D = A - B - C with borrow-out Bo, one cycle latency.
// Define FULL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output V.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = FS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic             Bo
`ifdef FULL_SUBTRACTOR_OVF_EN
  ,
  output logic             V
`endif
);

  if (WIDTH < 1 || WIDTH > FS_MAX_WIDTH) begin : g_width_chk
    $error("full_subtractor: WIDTH out of range 1..64");
  end

  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] d_comb;
  fs_result_t       res_d, res_q;

  assign bchain[0] = C;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    fs_cell u_cell (
      .a    (A[g]),
      .b    (B[g]),
      .bin  (bchain[g]),
      .d    (d_comb[g]),
      .bout (bchain[g+1])
    );
  end

  always_comb begin
    res_d                   = '0;
    res_d.diff[WIDTH-1:0]   = d_comb;
    res_d.borrow            = bchain[WIDTH];
`ifdef FULL_SUBTRACTOR_OVF_EN
    res_d.ovf               = fs_ovf(A[WIDTH-1], B[WIDTH-1], d_comb[WIDTH-1]);
`endif
  end

  // Load only on in_valid so idle-cycle inputs (possibly X) never reach the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) res_q <= res_d;
    end
  end

  assign D  = res_q.diff[WIDTH-1:0];
  assign Bo = res_q.borrow;
`ifdef FULL_SUBTRACTOR_OVF_EN
  assign V  = res_q.ovf;
`endif

  // Upper diff bits (and ovf when V is absent) are constant zero by construction.
  logic unused_res;
  assign unused_res = ^{res_q.diff, res_q.ovf};

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and table-driven checks of full_subtractor at WIDTH=1 and WIDTH=8.
module tb_full_subtractor;

  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic       a1, b1, c1, d1, bo1, ov1;
  logic [7:0] a8, b8, d8;
  logic       c8, bo8, ov8;
`ifdef FULL_SUBTRACTOR_OVF_EN
  logic       v1, v8;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a1), .B(b1), .C(c1),
    .out_valid(ov1), .D(d1), .Bo(bo1)
`ifdef FULL_SUBTRACTOR_OVF_EN
    , .V(v1)
`endif
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a8), .B(b8), .C(c8),
    .out_valid(ov8), .D(d8), .Bo(bo8)
`ifdef FULL_SUBTRACTOR_OVF_EN
    , .V(v8)
`endif
  );

  typedef struct {
    logic [7:0] a, b;
    logic       c;
    logic [7:0] d;
    logic       bo, v;
  } vec_t;

  vec_t t1[8];
  vec_t t8[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, then sit just past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // WIDTH=1 exhaustive (A,B,C) -> (D,Bo)
    t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0};
    t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1, 1'b0};
    t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
    t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0};
    t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0};
    t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};
    // WIDTH=8 boundaries and hand-computed cases
    t8[0] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    t8[1] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    t8[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    t8[3] = '{8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0};
    t8[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    t8[5] = '{8'h10, 8'h05, 1'b1, 8'h0A, 1'b0, 1'b0};
    t8[6] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0};
    t8[7] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0;
    a1 = 0; b1 = 0; c1 = 0; a8 = 0; b8 = 0; c8 = 0;
    repeat (2) step();
    chk("rst_d1", 64'(d1), 64'd0);
    chk("rst_bo1", 64'(bo1), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_d8", 64'(d8), 64'd0);
    chk("rst_ov8", 64'(ov8), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a1 = t1[i].a[0]; b1 = t1[i].b[0]; c1 = t1[i].c;
      step();
      chk($sformatf("w1_d[%0d]", i), 64'(d1), 64'(t1[i].d[0]));
      chk($sformatf("w1_bo[%0d]", i), 64'(bo1), 64'(t1[i].bo));
      chk($sformatf("w1_ov[%0d]", i), 64'(ov1), 64'd1);
    end

    // Reset mid-stream dominates a valid input
    @(negedge clk);
    rst = 1'b1; a1 = 1; b1 = 0; c1 = 1;
    step();
    chk("midrst_d", 64'(d1), 64'd0);
    chk("midrst_bo", 64'(bo1), 64'd0);
    chk("midrst_ov", 64'(ov1), 64'd0);

    @(negedge clk);
    rst = 1'b0; a1 = 1; b1 = 0; c1 = 0;
    step();
    chk("postrst_d", 64'(d1), 64'd1);
    chk("postrst_bo", 64'(bo1), 64'd0);
    chk("postrst_ov", 64'(ov1), 64'd1);

    // Hold: idle inputs must not disturb the stored result
    @(negedge clk);
    in_valid = 1'b0; a1 = 1; b1 = 1; c1 = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_d", 64'(d1), 64'd1);
      chk("hold_bo", 64'(bo1), 64'd0);
      chk("hold_ov", 64'(ov1), 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a8 = t8[i].a; b8 = t8[i].b; c8 = t8[i].c;
      step();
      chk($sformatf("w8_d[%0d]", i), 64'(d8), 64'(t8[i].d));
      chk($sformatf("w8_bo[%0d]", i), 64'(bo8), 64'(t8[i].bo));
`ifdef FULL_SUBTRACTOR_OVF_EN
      chk($sformatf("w8_v[%0d]", i), 64'(v8), 64'(t8[i].v));
`endif
    end

    // Back-to-back random stream against an integer reference
    for (int i = 0; i < 100; i++) begin
      int sres;
      logic [8:0] ures;
      @(negedge clk);
      in_valid = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      ures = {1'b0, a8} - {1'b0, b8} - {8'd0, c8};
      sres = int'($signed(a8)) - int'($signed(b8)) - int'(c8);
      step();
      chk($sformatf("rnd_d[%0d]", i), 64'(d8), 64'(ures[7:0]));
      chk($sformatf("rnd_bo[%0d]", i), 64'(bo8), 64'(ures[8]));
      chk($sformatf("rnd_ov[%0d]", i), 64'(ov8), 64'd1);
`ifdef FULL_SUBTRACTOR_OVF_EN
      chk($sformatf("rnd_v[%0d]", i), 64'(v8), 64'((sres < -128) || (sres > 127)));
`else
      if (sres > 1000) $display("unexpected model value %0d", sres);
`endif
    end

    @(negedge clk);
    in_valid = 1'b0;
    step();
    chk("tail_ov8", 64'(ov8), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
